// File: rtl/fb_write_arbiter_rr_picker.sv
`timescale 1ns/1ps
// Combinational round-robin search: starting just above last_idx, return the
// first requester whose bit is set, wrapping around NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_idx,
  output logic [1:0]         grant_idx,
  output logic               any_req
);

  int idx;

  always_comb begin
    grant_idx = 2'd0;
    any_req   = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_idx) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        grant_idx = 2'(idx);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
`timescale 1ns/1ps
// Framebuffer port-A write arbiter: round-robin grants whole bursts to one
// requester at a time, capped at MAX_BURST beats, with registered write outputs.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module fb_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 320
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_last,
  input  logic [NUM_REQ*`DISP_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]               req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                fb_we,
  output logic [`DISP_ADDR_WIDTH-1:0]         fb_addr,
  output logic [31:0]                         fb_wdata,
  output logic [1:0]                          grant_id,
  output logic                                busy
);

  localparam int   AW        = `DISP_ADDR_WIDTH;
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic          state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_owner_q, last_owner_d;
  logic [9:0]    beat_cnt_q, beat_cnt_d;
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [31:0]   fb_wdata_q, fb_wdata_d;

  logic          pick_any;
  logic [1:0]    pick_idx;
  logic          own_valid;
  logic          own_last;
  logic [AW-1:0] own_addr;
  logic [31:0]   own_wdata;
  logic          xfer;
  logic          burst_end;
  logic [9:0]    cnt_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (req_valid),
    .last_idx  (last_owner_q),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'd0;
      last_owner_q <= 2'(NUM_REQ - 1);
      beat_cnt_q   <= 10'd0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

  // Only the current owner's lanes are looked at; everyone else is ignored.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_wdata = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_addr  = req_addr[i*AW +: AW];
        own_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  assign xfer      = (state_q == ST_LOCKED) && own_valid;
  assign cnt_inc   = beat_cnt_q + 10'd1;
  assign burst_end = xfer && (own_last || (cnt_inc == 10'(MAX_BURST)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_any)  state_d = ST_LOCKED;
      ST_LOCKED: if (burst_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    fb_we_d      = xfer;
    fb_addr_d    = xfer ? own_addr : fb_addr_q;
    fb_wdata_d   = xfer ? own_wdata : fb_wdata_q;
    if (state_q == ST_IDLE && pick_any) begin
      grant_d    = pick_idx;
      beat_cnt_d = 10'd0;
    end
    if (xfer) begin
      beat_cnt_d = burst_end ? 10'd0 : cnt_inc;
      if (burst_end) last_owner_d = grant_q;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_q == 2'(i));
      end
    end
    busy = (state_q == ST_LOCKED);
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for fb_write_arbiter: table-driven grant vectors plus
// hand-written burst, round-robin, fairness, stall, reset and ignore sequences.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module tb_fb_write_arbiter;

  localparam int AW = `DISP_ADDR_WIDTH;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req_valid;
  logic [2:0]      req_last;
  logic [3*AW-1:0] req_addr;
  logic [95:0]     req_wdata;
  logic [2:0]      req_ready;
  logic            fb_we;
  logic [AW-1:0]   fb_addr;
  logic [31:0]     fb_wdata;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .NUM_REQ   (3),
    .MAX_BURST (320)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [2:0] valid;
    int         ngr;
    int         g0;
    int         g1;
    int         g2;
  } vec_t;

  wr_t sb[$];
  int  exp_grant_q[$];

  int total = 0;
  int bad   = 0;

  int src_base[3], src_dbase[3], src_dstep[3], src_len[3], src_limit[3];
  int src_sent[3], stall_at[3], stall_left[3];
  bit acc[3];

  int cycle, first_we, last_we, we_count, idle_run;
  bit busy_prev, have_prev_fall;
  int locked_cycles[4];
  int ready_cnt[3];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [AW-1:0] beat_addr(int i, int k);
    return AW'(src_base[i] + k);
  endfunction

  function automatic logic [31:0] beat_data(int i, int k);
    return 32'(src_dbase[i] + k * src_dstep[i]);
  endfunction

  task automatic expect_burst(input int i, input int k0, input int n);
    wr_t w;
    for (int k = k0; k < k0 + n; k++) begin
      w.addr = beat_addr(i, k);
      w.data = beat_data(i, k);
      sb.push_back(w);
    end
  endtask

  task automatic config_src(input int i, input int base, input int dbase, input int dstep,
                            input int len, input int limit);
    src_base[i]  = base;
    src_dbase[i] = dbase;
    src_dstep[i] = dstep;
    src_len[i]   = len;
    src_limit[i] = limit;
  endtask

  task automatic drive_inputs();
    bit present;
    for (int i = 0; i < 3; i++) begin
      present = (src_sent[i] < src_limit[i]) && (stall_left[i] == 0);
      if (stall_left[i] > 0) stall_left[i]--;
      req_valid[i] = present;
      req_last[i]  = present && (src_len[i] != 0) && (((src_sent[i] + 1) % src_len[i]) == 0);
      req_addr[i*AW +: AW]  = beat_addr(i, src_sent[i]);
      req_wdata[i*32 +: 32] = beat_data(i, src_sent[i]);
    end
  endtask

  // Everything observable is checked on the falling edge, between active edges.
  task automatic sample_outputs();
    wr_t e;
    @(negedge clk);
    if (busy) begin
      if (!busy_prev) begin
        checkOutput("grant_pending", 32'(exp_grant_q.size() > 0), 32'd1);
        if (exp_grant_q.size() > 0) checkOutput("grant_id", 32'(grant_id), 32'(exp_grant_q.pop_front()));
        if (have_prev_fall) checkOutput("idle_gap", 32'(idle_run), 32'd1);
      end
      idle_run = 0;
      locked_cycles[grant_id]++;
    end else begin
      idle_run++;
      if (busy_prev) have_prev_fall = 1'b1;
      checkOutput("ready_idle", 32'(req_ready), 32'd0);
    end
    for (int i = 0; i < 3; i++) if (req_ready[i]) ready_cnt[i]++;
    if (fb_we) begin
      we_count++;
      if (first_we < 0) first_we = cycle;
      last_we = cycle;
      checkOutput("write_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("fb_addr", 32'(fb_addr), 32'(e.addr));
        checkOutput("fb_wdata", fb_wdata, e.data);
      end
    end
    for (int i = 0; i < 3; i++) acc[i] = req_valid[i] && req_ready[i];
    busy_prev = busy;
    cycle++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        src_sent[i]++;
        if (src_sent[i] == stall_at[i]) begin
          stall_left[i] = 5;
          stall_at[i]   = -1;
        end
      end
    end
    drive_inputs();
  endtask

  task automatic applyStimulus();
    sample_outputs();
    advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_we"}, 32'(fb_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(fb_addr), 32'd0);
    checkOutput({tag, "_wdata"}, fb_wdata, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant_id), 32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      config_src(i, 0, 0, 0, 0, 0);
      src_sent[i]   = 0;
      stall_at[i]   = -1;
      stall_left[i] = 0;
      acc[i]        = 1'b0;
    end
    drive_inputs();
    sb.delete();
    exp_grant_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
  endtask

  task automatic release_reset();
    drive_inputs();
    cycle          = 0;
    first_we       = -1;
    last_we        = -1;
    we_count       = 0;
    idle_run       = 0;
    busy_prev      = 1'b0;
    have_prev_fall = 1'b0;
    for (int i = 0; i < 4; i++) locked_cycles[i] = 0;
    for (int i = 0; i < 3; i++) ready_cnt[i] = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || exp_grant_q.size() != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_in_time"}, 32'(n < budget), 32'd1);
    repeat (4) applyStimulus();
    checkOutput({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{valid: 3'b111, ngr: 3, g0: 0, g1: 1, g2: 2};
    vecs[1] = '{valid: 3'b101, ngr: 2, g0: 0, g1: 2, g2: 0};
    vecs[2] = '{valid: 3'b110, ngr: 2, g0: 1, g1: 2, g2: 0};
    vecs[3] = '{valid: 3'b100, ngr: 1, g0: 2, g1: 0, g2: 0};
    vecs[4] = '{valid: 3'b011, ngr: 2, g0: 0, g1: 1, g2: 0};
    vecs[5] = '{valid: 3'b010, ngr: 1, g0: 1, g1: 0, g2: 0};

    $display("[TB] start");
    apply_reset();

    // Single-beat bursts from a set of requesters: grant order from reset.
    for (int v = 0; v < 6; v++) begin
      int gl[3];
      apply_reset();
      gl[0] = vecs[v].g0;
      gl[1] = vecs[v].g1;
      gl[2] = vecs[v].g2;
      for (int i = 0; i < 3; i++)
        if (vecs[v].valid[i]) config_src(i, 200 + i * 16, 'hA00 + i * 'h10, 1, 1, 1);
      for (int g = 0; g < vecs[v].ngr; g++) begin
        exp_grant_q.push_back(gl[g]);
        expect_burst(gl[g], 0, 1);
      end
      release_reset();
      run_until_done("vec", 40);
    end

    // Single 4-beat burst with first write three cycles after release.
    apply_reset();
    config_src(0, 100, 'h555, 0, 4, 4);
    exp_grant_q.push_back(0);
    expect_burst(0, 0, 4);
    release_reset();
    run_until_done("single", 40);
    checkOutput("single_first_we", 32'(first_we), 32'd2);
    checkOutput("single_we_span", 32'(last_we - first_we), 32'd3);
    checkOutput("single_we_count", 32'(we_count), 32'd4);
    checkOutput("single_locked", 32'(locked_cycles[0]), 32'd4);

    // Round robin with 2-beat bursts from all three requesters.
    apply_reset();
    for (int i = 0; i < 3; i++) config_src(i, 300 + i * 32, 'h100 * (i + 1), 1, 2, 4);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++) begin
        exp_grant_q.push_back(i);
        expect_burst(i, r * 2, 2);
      end
    release_reset();
    run_until_done("rr", 80);
    for (int i = 0; i < 3; i++) checkOutput("rr_locked", 32'(locked_cycles[i]), 32'd4);

    // Endless streams from 1 and 2 are cut at exactly 320 beats per grant.
    apply_reset();
    config_src(1, 0, 'h10000, 1, 0, 960);
    config_src(2, 40000, 'h20000, 3, 0, 960);
    for (int c = 0; c < 3; c++) begin
      exp_grant_q.push_back(1);
      expect_burst(1, c * 320, 320);
      exp_grant_q.push_back(2);
      expect_burst(2, c * 320, 320);
    end
    release_reset();
    run_until_done("fair", 3000);
    checkOutput("fair_we_count", 32'(we_count), 32'd1920);
    checkOutput("fair_locked1", 32'(locked_cycles[1]), 32'd960);

    // Owner stalls for five cycles after its third beat; grant must not move.
    apply_reset();
    config_src(0, 600, 'h4000, 1, 8, 8);
    config_src(1, 700, 'h5000, 1, 2, 2);
    stall_at[0] = 3;
    exp_grant_q.push_back(0);
    expect_burst(0, 0, 8);
    exp_grant_q.push_back(1);
    expect_burst(1, 0, 2);
    release_reset();
    run_until_done("stall", 80);
    checkOutput("stall_locked0", 32'(locked_cycles[0]), 32'd13);
    checkOutput("stall_locked1", 32'(locked_cycles[1]), 32'd2);

    // Reset pulsed while the seventh write is on the bus.
    apply_reset();
    config_src(0, 800, 'h3000, 1, 16, 16);
    exp_grant_q.push_back(0);
    expect_burst(0, 0, 7);
    release_reset();
    for (int n = 0; n < 50; n++) begin
      sample_outputs();
      if (we_count >= 7) break;
      advance();
    end
    checkOutput("rstmid_reached", 32'(we_count), 32'd7);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    checkOutput("rstmid_sb_left", 32'(sb.size()), 32'd0);
    apply_reset();
    config_src(0, 850, 'h6000, 1, 1, 1);
    config_src(2, 870, 'h7000, 1, 1, 1);
    exp_grant_q.push_back(0);
    expect_burst(0, 0, 1);
    exp_grant_q.push_back(2);
    expect_burst(2, 0, 1);
    release_reset();
    run_until_done("rstmid_after", 40);

    // Requester 2 holds last while requester 0 owns the grant.
    apply_reset();
    config_src(0, 1000, 'h8000, 1, 6, 6);
    config_src(2, 1100, 'h9000, 1, 1, 1);
    exp_grant_q.push_back(0);
    expect_burst(0, 0, 6);
    exp_grant_q.push_back(2);
    expect_burst(2, 0, 1);
    release_reset();
    run_until_done("ignore", 60);
    checkOutput("ignore_locked0", 32'(locked_cycles[0]), 32'd6);
    checkOutput("ignore_ready2", 32'(ready_cnt[2]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of framebuffer write requesters (2..4).
REQ-002 Parameter MAX_BURST, default 320, maximum beats per grant before forced release (fairness limit, 1..1023).
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous, active-low reset.
REQ-005 Port req_valid, input, NUM_REQ, per-requester beat-valid flag.
REQ-006 Port req_last, input, NUM_REQ, per-requester flag marking the final beat of a burst.
REQ-007 Port req_addr, input, NUM_REQ*`DISP_ADDR_WIDTH, flattened per-requester pixel addresses; requester i occupies slice i.
REQ-008 Port req_wdata, input, NUM_REQ*32, flattened per-requester pixel data; requester i occupies slice i.
REQ-009 Port req_ready, output, NUM_REQ, per-requester beat-accept flag.
REQ-010 Port fb_we, output, 1, framebuffer port-A write enable.
REQ-011 Port fb_addr, output, `DISP_ADDR_WIDTH, framebuffer port-A address.
REQ-012 Port fb_wdata, output, 32, framebuffer port-A data, with RGB444 in bits [11:0].
REQ-013 Port grant_id, output, 2, index of the current owner; valid while busy=1.
REQ-014 Port busy, output, 1, asserted while a grant is held.

Function
REQ-015 The arbiter SHALL implement a two-state FSM with states IDLE and LOCKED.
REQ-016 In IDLE, if any req_valid bit is set, the arbiter SHALL select one requester round-robin, searching upward from (last_owner+1) mod NUM_REQ with wrap, and SHALL enter LOCKED on the next cycle with grant_id set to the selected index.
REQ-017 In IDLE with no req_valid bit set, the arbiter SHALL remain in IDLE and keep last_owner unchanged.
REQ-018 The arbiter SHALL drive req_ready[i] combinationally as (state==LOCKED && grant_id==i), SHALL drive every other ready bit to 0, and SHALL hold all ready bits at 0 in IDLE.
REQ-019 A beat SHALL transfer exactly when req_valid[g] and req_ready[g] are both high, where g is grant_id.
REQ-020 On a transferred beat, the arbiter SHALL register the owner's addr and wdata to fb_addr and fb_wdata and assert fb_we=1 on the following cycle, giving 1-cycle latency.
REQ-021 On any cycle without a transfer, the arbiter SHALL drive fb_we=0 and SHALL hold fb_addr and fb_wdata at their last values.
REQ-022 If the owner deasserts valid mid-burst, the arbiter SHALL keep the grant and stall with no transfer; it SHALL NOT apply a timeout.
REQ-023 A 10-bit beat counter SHALL clear on entry to LOCKED and SHALL increment by 1 on each transferred beat.
REQ-024 A transferred beat with req_last[g]=1 SHALL return the FSM to IDLE, set last_owner to g, and clear the beat counter.
REQ-025 A transferred beat that brings the counter to MAX_BURST SHALL force a return to IDLE exactly as REQ-024 does, even if req_last[g]=0; the requester SHALL simply resume when it is next granted.
REQ-026 The arbiter SHALL insert exactly one IDLE cycle between consecutive grants, so the maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
REQ-027 With a single active requester, the arbiter SHALL re-grant that requester after the one IDLE cycle.
REQ-028 The arbiter SHALL ignore req_last and valid from non-owners.
REQ-029 The arbiter SHALL hold busy=1 exactly while state==LOCKED.

Reset
REQ-030 While reset_n=0, the arbiter SHALL asynchronously force: state=IDLE, fb_we=0, fb_addr=0, fb_wdata=0, grant_id=0, busy=0, req_ready=0, beat counter=0, last_owner=NUM_REQ-1 (so requester 0 is searched first).
REQ-031 A reset asserted mid-burst SHALL abort the burst with no further writes; after release, arbitration SHALL restart from requester 0.
REQ-032 The first possible fb_we SHALL occur 3 cycles after reset_n rises with a valid request present: arbitrate, then accept, then write.

Structure
REQ-033 The address width SHALL come from `DISP_ADDR_WIDTH in memory/memory_sizes.vh.
REQ-034 The FSM state encodings SHALL be defined as localparams inside the module.
REQ-035 The round-robin search SHALL be implemented as a purely combinational sub-module rr_picker (inputs: request vector and last index; outputs: grant index and any-flag).
REQ-036 The block SHALL NOT create a new package.

Verification
REQ-037 Single burst: requester 0 sends 4 beats at addr 100..103, data 0x555, with last on beat 4 -> fb_we high for 4 consecutive cycles carrying addr 100..103, then busy falls.
REQ-038 Round-robin: all 3 requesters continuously valid with 2-beat bursts -> grant order 0,1,2,0,1,2 with exactly one idle cycle between grants.
REQ-039 Fairness limit: MAX_BURST=320, requester 1 streams 76800 beats with no last and requester 2 is also valid -> grant_id alternates 1,2 every 320 beats, and no write is lost or duplicated.
REQ-040 Stall: the owner drops valid for 5 cycles mid-burst -> busy stays 1, fb_we=0 for those cycles, the grant does not move, and the burst resumes with the next address.
REQ-041 Reset mid-burst: reset_n is pulsed low at beat 7 -> fb_we drops to 0 immediately and all outputs read 0; after release, requester 0 is granted first.
REQ-042 Non-owner ignore: requester 2 asserts last while requester 0 owns the grant -> no state change and req_ready[2] stays 0.
